// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter with optional parity and line break.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   DATA_BITS    : data bits per frame (5..9), sent LSB first
//   PARITY       : 0 none, 1 odd, 2 even
//   STOP_BITS    : stop bits per frame (1 or 2)
//
// Ports
//   CLK_100_I  in   clock, rising edge
//   RSTN_I     in   asynchronous active-low reset
//   DATA_I     in   word to transmit, captured when VALID_I && READY_O
//   VALID_I    in   DATA_I is valid
//   READY_O    out  block can accept a word (registered)
//   BREAK_I    in   hold the line low while high (sampled in IDLE only)
//   SERIAL_O   out  serial line, idles high (registered)
//   BUSY_O     out  frame or break in progress (registered)
module uart_tx_param #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLK_100_I,
  input  logic                 RSTN_I,
  input  logic [DATA_BITS-1:0] DATA_I,
  input  logic                 VALID_I,
  output logic                 READY_O,
  input  logic                 BREAK_I,
  output logic                 SERIAL_O,
  output logic                 BUSY_O
);

  // Elaboration-time parameter checks
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_INV   = (PARITY == 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BRK   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic                 bit_end_c;
  logic [CNT_W-1:0]     cnt_next_c;

  // Bit timer: last cycle of the current bit, and the wrapped next count
  assign bit_end_c  = (cnt_q == CNT_LAST);
  assign cnt_next_c = bit_end_c ? '0 : cnt_q + CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge CLK_100_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = serial_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        serial_d = 1'b1;
        // Break has priority over a pending word
        if (BREAK_I) begin
          state_d  = BRK;
          serial_d = 1'b0;
        end else if (VALID_I && ready_q) begin
          state_d  = START;
          serial_d = 1'b0;
          shift_d  = DATA_I;
          par_d    = (^DATA_I) ^ PAR_INV;
        end
      end

      START: begin
        cnt_d = cnt_next_c;
        if (bit_end_c) begin
          state_d  = DATA;
          idx_d    = '0;
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
        end
      end

      DATA: begin
        cnt_d = cnt_next_c;
        if (bit_end_c) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (HAS_PAR) begin
              state_d  = PAR;
              serial_d = par_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
      end

      PAR: begin
        cnt_d = cnt_next_c;
        if (bit_end_c) begin
          state_d  = STOP;
          idx_d    = '0;
          serial_d = 1'b1;
        end
      end

      STOP: begin
        cnt_d    = cnt_next_c;
        serial_d = 1'b1;
        if (bit_end_c) begin
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      BRK: begin
        // Line low marks the hold phase; line high marks the one-bit recovery
        if (!serial_q) begin
          cnt_d = '0;
          if (!BREAK_I) begin
            serial_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_next_c;
          if (bit_end_c) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        serial_d = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE) && !BREAK_I;
    busy_d  = (state_d != IDLE);
  end

  assign READY_O  = ready_q;
  assign SERIAL_O = serial_q;
  assign BUSY_O   = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four instances with different frame
// formats share one clock/reset; frames are checked cycle by cycle.
module tb_uart_tx_param;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [3:0] valid_v, brk_v;
  logic [3:0] ready_w, serial_w, busy_w;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .CLK_100_I(clk), .RSTN_I(rstn), .DATA_I(d0), .VALID_I(valid_v[0]), .READY_O(ready_w[0]),
    .BREAK_I(brk_v[0]), .SERIAL_O(serial_w[0]), .BUSY_O(busy_w[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .CLK_100_I(clk), .RSTN_I(rstn), .DATA_I(d1), .VALID_I(valid_v[1]), .READY_O(ready_w[1]),
    .BREAK_I(brk_v[1]), .SERIAL_O(serial_w[1]), .BUSY_O(busy_w[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .CLK_100_I(clk), .RSTN_I(rstn), .DATA_I(d2), .VALID_I(valid_v[2]), .READY_O(ready_w[2]),
    .BREAK_I(brk_v[2]), .SERIAL_O(serial_w[2]), .BUSY_O(busy_w[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .CLK_100_I(clk), .RSTN_I(rstn), .DATA_I(d3), .VALID_I(valid_v[3]), .READY_O(ready_w[3]),
    .BREAK_I(brk_v[3]), .SERIAL_O(serial_w[3]), .BUSY_O(busy_w[3]));

  // Frame format of each instance
  function automatic int f_db(int k);
    return (k == 3) ? 5 : 8;
  endfunction
  function automatic int f_par(int k);
    return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
  endfunction
  function automatic int f_stop(int k);
    return (k == 1) ? 2 : 1;
  endfunction

  // Reference model: list of line levels, one per bit time, element 0 sent first
  task automatic model_frame(input int k, input logic [8:0] data,
                             output logic [11:0] bits, output int len);
    logic p;
    bits = '0;
    len  = 0;
    p    = 1'b0;
    bits[len] = 1'b0;
    len++;
    for (int i = 0; i < f_db(k); i++) begin
      bits[len] = data[i];
      p = p ^ data[i];
      len++;
    end
    if (f_par(k) != 0) begin
      bits[len] = (f_par(k) == 1) ? ~p : p;
      len++;
    end
    for (int s = 0; s < f_stop(k); s++) begin
      bits[len] = 1'b1;
      len++;
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_data(input int k, input logic [8:0] d);
    case (k)
      0: d0 = d[7:0];
      1: d1 = d[7:0];
      2: d2 = d[7:0];
      default: d3 = d[4:0];
    endcase
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic wait_ready(input int k);
    int t;
    t = 0;
    while (ready_w[k] !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("u%0d ready_wait", k), ready_w[k], 1'b1);
  endtask

  // Present a word; returns just after the accepting edge
  task automatic send(input int k, input logic [8:0] data, input bit hold);
    wait_ready(k);
    drive_data(k, data);
    valid_v[k] = 1'b1;
    @(posedge clk); #1;
    if (!hold) valid_v[k] = 1'b0;
  endtask

  // Check every cycle of a frame; optionally disturb DATA_I/BREAK_I mid-frame
  task automatic check_frame(input int k, input logic [11:0] bits, input int len,
                             input logic [8:0] data, input bit disturb);
    for (int j = 0; j < len * int'(CPB); j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("u%0d serial bit%0d cyc%0d", k, j / int'(CPB), j), serial_w[k], bits[j / int'(CPB)]);
      chk($sformatf("u%0d ready_low cyc%0d", k, j), ready_w[k], 1'b0);
      chk($sformatf("u%0d busy cyc%0d", k, j), busy_w[k], 1'b1);
      if (disturb && j == 10) begin
        drive_data(k, ~data);
        brk_v[k] = 1'b1;
      end
      if (disturb && j == len * int'(CPB) - 3) brk_v[k] = 1'b0;
    end
  endtask

  task automatic end_check(input int k);
    @(posedge clk); #1;
    chk($sformatf("u%0d ready_after", k), ready_w[k], 1'b1);
    chk($sformatf("u%0d busy_after", k), busy_w[k], 1'b0);
    chk($sformatf("u%0d serial_idle", k), serial_w[k], 1'b1);
  endtask

  typedef struct {
    int          k;
    logic [8:0]  data;
    logic [11:0] exp_bits;
    int          exp_len;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bits;
    int          len;
    logic [8:0]  data;
    int          k;

    // Hand-derived frames: bit i of exp_bits is the i-th bit time on the line
    tbl[0] = '{0, 9'h0A5, 12'h34A, 10};
    tbl[1] = '{1, 9'h007, 12'hE0E, 12};
    tbl[2] = '{2, 9'h007, 12'h40E, 11};
    tbl[3] = '{3, 9'h01F, 12'h07E, 7};
    tbl[4] = '{0, 9'h000, 12'h200, 10};
    tbl[5] = '{0, 9'h0FF, 12'h3FE, 10};
    tbl[6] = '{3, 9'h00A, 12'h054, 7};
    tbl[7] = '{1, 9'h080, 12'hF00, 12};

    rstn    = 1'b0;
    valid_v = '0;
    brk_v   = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    // Reset values, then READY on the first edge after release
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d rst serial", i), serial_w[i], 1'b1);
      chk($sformatf("u%0d rst ready", i), ready_w[i], 1'b0);
      chk($sformatf("u%0d rst busy", i), busy_w[i], 1'b0);
    end
    rstn = 1'b1;
    #1;
    chk("u0 ready_before_edge", ready_w[0], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("u%0d ready_first_edge", i), ready_w[i], 1'b1);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      send(tbl[v].k, tbl[v].data, 1'b0);
      check_frame(tbl[v].k, tbl[v].exp_bits, tbl[v].exp_len, tbl[v].data, 1'b0);
      end_check(tbl[v].k);
    end

    // Back-to-back 5-bit frames with VALID_I held: exactly one idle cycle between
    model_frame(3, 9'h01F, bits, len);
    send(3, 9'h01F, 1'b1);
    check_frame(3, bits, len, 9'h01F, 1'b0);
    @(posedge clk); #1;
    chk("u3 b2b idle ready", ready_w[3], 1'b1);
    chk("u3 b2b idle serial", serial_w[3], 1'b1);
    chk("u3 b2b idle busy", busy_w[3], 1'b0);
    @(posedge clk); #1;
    valid_v[3] = 1'b0;
    check_frame(3, bits, len, 9'h01F, 1'b0);
    end_check(3);

    // Break with VALID_I: low 20 cycles, high one bit time, then ready; no frame
    wait_ready(0);
    drive_data(0, 9'h055);
    valid_v[0] = 1'b1;
    brk_v[0]   = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      chk($sformatf("u0 brk low cyc%0d", j), serial_w[0], 1'b0);
      chk($sformatf("u0 brk ready cyc%0d", j), ready_w[0], 1'b0);
      chk($sformatf("u0 brk busy cyc%0d", j), busy_w[0], 1'b1);
    end
    brk_v[0]   = 1'b0;
    valid_v[0] = 1'b0;
    for (int j = 0; j < int'(CPB); j++) begin
      @(posedge clk); #1;
      chk($sformatf("u0 brk recover cyc%0d", j), serial_w[0], 1'b1);
      chk($sformatf("u0 brk recover ready cyc%0d", j), ready_w[0], 1'b0);
    end
    end_check(0);
    @(posedge clk); #1;
    chk("u0 brk no_frame", serial_w[0], 1'b1);

    // Frame bits unchanged by DATA_I/BREAK_I activity mid-frame
    model_frame(2, 9'h0C3, bits, len);
    send(2, 9'h0C3, 1'b0);
    check_frame(2, bits, len, 9'h0C3, 1'b1);
    end_check(2);

    // Reset during the 3rd data bit (0x5A: that bit is 0 on the line)
    send(0, 9'h05A, 1'b0);
    for (int j = 1; j <= 13; j++) begin
      @(posedge clk); #1;
    end
    chk("u0 pre_reset serial", serial_w[0], 1'b0);
    rstn = 1'b0;
    #1;
    chk("u0 midrst serial", serial_w[0], 1'b1);
    chk("u0 midrst busy", busy_w[0], 1'b0);
    chk("u0 midrst ready", ready_w[0], 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("u0 post_reset ready", ready_w[0], 1'b1);
    model_frame(0, 9'h03C, bits, len);
    send(0, 9'h03C, 1'b0);
    check_frame(0, bits, len, 9'h03C, 1'b0);
    end_check(0);

    // Randomized frames against the reference model
    for (int r = 0; r < 30; r++) begin
      k    = int'($urandom_range(0, 3));
      data = 9'($urandom);
      model_frame(k, data, bits, len);
      send(k, data, 1'b0);
      check_frame(k, bits, len, data, 1'($urandom_range(0, 1)));
      end_check(k);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
